// File: rtl/crossing_controller.sv
// Pelican-crossing sequencer: drives the shared RAG lamp ({red,amber,green}),
// the walk lamp and a latched pedestrian request.
//
// state       | meaning
// S_RED       | red (100); walk lit only when entered from AMBER
// S_RED_AMBER | red+amber (110), preparing for green
// S_GREEN     | green (001); held until minimum dwell met and a request is pending
// S_AMBER     | amber (010), heading to a served red
module crossing_controller #(
  parameter int RED_CYC   = 4,
  parameter int RA_CYC    = 2,
  parameter int MIN_GREEN = 6,
  parameter int AMBER_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] rag,
  output logic       walk,
  output logic       req_pending
);

  localparam int MAX_A = (RED_CYC > RA_CYC) ? RED_CYC : RA_CYC;
  localparam int MAX_B = (MIN_GREEN > AMBER_CYC) ? MIN_GREEN : AMBER_CYC;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW = $clog2(MAX_ALL + 1);

  localparam logic [TW-1:0] RED_LAST   = TW'(RED_CYC - 1);
  localparam logic [TW-1:0] RA_LAST    = TW'(RA_CYC - 1);
  localparam logic [TW-1:0] GREEN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] AMBER_LAST = TW'(AMBER_CYC - 1);

  typedef enum logic [1:0] {
    S_RED       = 2'd0,
    S_RED_AMBER = 2'd1,
    S_GREEN     = 2'd2,
    S_AMBER     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          walk_q, walk_d;
  logic          req_q, req_d;
  logic [2:0]    rag_q, rag_d;
  logic          served;

  function automatic logic [2:0] rag_of(input state_t s);
    case (s)
      S_RED:       rag_of = 3'b100;
      S_RED_AMBER: rag_of = 3'b110;
      S_GREEN:     rag_of = 3'b001;
      S_AMBER:     rag_of = 3'b010;
      default:     rag_of = 3'b100;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    walk_d  = walk_q;
    served  = 1'b0;
    if (enable) begin
      case (state_q)
        S_RED: begin
          if (timer_q == RED_LAST) begin
            state_d = S_RED_AMBER;
            timer_d = '0;
            walk_d  = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_RED_AMBER: begin
          if (timer_q == RA_LAST) begin
            state_d = S_GREEN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_GREEN: begin
          // Timer parks at the minimum-dwell value until a request arrives.
          if (timer_q == GREEN_LAST) begin
            if (req_q) begin
              state_d = S_AMBER;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_AMBER: begin
          if (timer_q == AMBER_LAST) begin
            state_d = S_RED;
            timer_d = '0;
            walk_d  = 1'b1;
            served  = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_RED;
          timer_d = '0;
        end
      endcase
    end

    // Serving the request beats a same-cycle press; presses during walk are ignored.
    if (served) begin
      req_d = 1'b0;
    end else if (ped_req && !walk_q) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end

    rag_d = rag_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RED;
      timer_q <= '0;
      walk_q  <= 1'b0;
      req_q   <= 1'b0;
      rag_q   <= 3'b100;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      walk_q  <= walk_d;
      req_q   <= req_d;
      rag_q   <= rag_d;
    end
  end

  assign rag         = rag_q;
  assign walk        = walk_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_crossing_controller.sv
// Scoreboard bench for crossing_controller: a phase/remaining-count model
// pushes expected {rag,walk,req_pending} per edge, popped after the edge.
module tb_crossing_controller;

  localparam int RED_CYC   = 4;
  localparam int RA_CYC    = 2;
  localparam int MIN_GREEN = 6;
  localparam int AMBER_CYC = 3;

  localparam int P_RED   = 0;
  localparam int P_RA    = 1;
  localparam int P_GREEN = 2;
  localparam int P_AMBER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] rag;
  logic       walk;
  logic       req_pending;

  always #5 clk = ~clk;

  crossing_controller #(
    .RED_CYC  (RED_CYC),
    .RA_CYC   (RA_CYC),
    .MIN_GREEN(MIN_GREEN),
    .AMBER_CYC(AMBER_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ped_req    (ped_req),
    .rag        (rag),
    .walk       (walk),
    .req_pending(req_pending)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  int   m_state = P_RED;
  int   m_left  = RED_CYC;
  int   m_gseen = 0;
  logic m_walk  = 1'b0;
  logic m_req   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_rag(input int s);
    case (s)
      P_RED:   return 3'b100;
      P_RA:    return 3'b110;
      P_GREEN: return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic p);
    logic w_old;
    logic req_old;
    bit   served;
    w_old   = m_walk;
    req_old = m_req;
    served  = 1'b0;
    if (r) begin
      m_state = P_RED;
      m_left  = RED_CYC;
      m_gseen = 0;
      m_walk  = 1'b0;
      m_req   = 1'b0;
    end else begin
      if (e) begin
        case (m_state)
          P_RED: begin
            m_left--;
            if (m_left == 0) begin
              m_state = P_RA;
              m_left  = RA_CYC;
              m_walk  = 1'b0;
            end
          end
          P_RA: begin
            m_left--;
            if (m_left == 0) begin
              m_state = P_GREEN;
              m_gseen = 0;
            end
          end
          P_GREEN: begin
            if (m_gseen < MIN_GREEN) m_gseen++;
            if (m_gseen >= MIN_GREEN && req_old) begin
              m_state = P_AMBER;
              m_left  = AMBER_CYC;
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) begin
              m_state = P_RED;
              m_left  = RED_CYC;
              m_walk  = 1'b1;
              served  = 1'b1;
            end
          end
        endcase
      end
      if (served) m_req = 1'b0;
      else if (p && !w_old) m_req = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic p, input string tag);
    logic [4:0] exp_v;
    rst     = r;
    enable  = e;
    ped_req = p;
    model_edge(r, e, p);
    exp_q.push_back({m_rag(m_state), m_walk, m_req});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check(tag, 32'({rag, walk, req_pending}), 32'(exp_v));
  endtask

  task automatic run(input int n, input logic e, input logic p, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, e, p, tag);
  endtask

  initial begin
    int gcount;
    bit seen_amber;

    step(1'b1, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b0, "reset");
    check("reset_rag", 32'(rag), 32'(3'b100));
    check("reset_walk", 32'(walk), 32'(1'b0));
    check("reset_req", 32'(req_pending), 32'(1'b0));

    // Free run with no requests: green must hold
    run(RED_CYC + RA_CYC, 1'b1, 1'b0, "t1_red_ra");
    run(22, 1'b1, 1'b0, "t1_green_hold");
    check("t1_green", 32'(rag), 32'(3'b001));

    // Pulse in the second green cycle; green lasts the minimum dwell
    step(1'b1, 1'b1, 1'b0, "t2_rst");
    gcount = 0;
    seen_amber = 1'b0;
    for (int i = 0; i < 40 && !seen_amber; i++) begin
      step(1'b0, 1'b1, (i == 7), "t2_seq");
      if (rag == 3'b001) gcount++;
      if (rag == 3'b010) seen_amber = 1'b1;
    end
    check("t2_amber_reached", 32'(seen_amber), 32'(1));
    check("t2_green_len", 32'(gcount), 32'(MIN_GREEN));
    run(AMBER_CYC, 1'b1, 1'b0, "t2_amber");
    check("t2_red_rag", 32'(rag), 32'(3'b100));
    check("t2_red_walk", 32'(walk), 32'(1'b1));
    check("t2_red_req", 32'(req_pending), 32'(1'b0));

    // Press during walk is ignored
    step(1'b0, 1'b1, 1'b1, "t3_walk_ped");
    check("t3_req_ignored", 32'(req_pending), 32'(1'b0));
    run(30, 1'b1, 1'b0, "t3_hold");
    check("t3_green", 32'(rag), 32'(3'b001));

    // Freeze for 5 cycles after the first amber cycle
    step(1'b0, 1'b1, 1'b1, "t4_req");
    step(1'b0, 1'b1, 1'b0, "t4_to_amber");
    check("t4_amber_entry", 32'(rag), 32'(3'b010));
    step(1'b0, 1'b1, 1'b0, "t4_amber1");
    run(5, 1'b0, 1'b0, "t4_freeze");
    check("t4_frozen_rag", 32'(rag), 32'(3'b010));
    step(1'b0, 1'b1, 1'b0, "t4_amber2");
    check("t4_amber2_rag", 32'(rag), 32'(3'b010));
    step(1'b0, 1'b1, 1'b0, "t4_amber3");
    check("t4_red_rag", 32'(rag), 32'(3'b100));

    // Request latches while frozen in green
    run(14, 1'b1, 1'b0, "frz_reach_green");
    run(3, 1'b0, 1'b1, "frz_ped");
    check("frz_req", 32'(req_pending), 32'(1'b1));
    check("frz_rag", 32'(rag), 32'(3'b001));

    // Reset mid-green with a pending request
    step(1'b1, 1'b1, 1'b0, "t5_rst");
    check("t5_rag", 32'(rag), 32'(3'b100));
    check("t5_walk", 32'(walk), 32'(1'b0));
    check("t5_req", 32'(req_pending), 32'(1'b0));
    run(26, 1'b1, 1'b0, "t5_restart");
    check("t5_green", 32'(rag), 32'(3'b001));

    // Held request: steady 15-cycle period
    run(60, 1'b1, 1'b1, "t6_held");

    // Mixed random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
